// File: rtl/fmap_readout_256.sv
// Streams a captured PIX_H x PIX_H feature map out of the fmap BRAM (port B)
// as raster-order 8-bit pixels, one column word re-read per pixel.
module fmap_readout_256 #(
  parameter int          PIX_H     = 24,
  parameter logic [11:0] BASE_ADDR = 12'h000,
  parameter int          RD_LAT    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [11:0]        bram_addr_b,
  output logic               bram_en_b,
  input  logic [8*PIX_H-1:0] bram_rddata_b,
  output logic [7:0]         m_pix_data,
  output logic               m_pix_valid,
  input  logic               m_pix_ready,
  output logic               m_pix_sof,
  output logic               m_pix_last,
  output logic               busy,
  output logic               frame_done
);

  localparam int CW = (PIX_H > 1) ? $clog2(PIX_H) : 1;
  localparam int WW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [CW-1:0] LAST_POS = CW'(PIX_H - 1);
  localparam logic [WW-1:0] WAIT_END = WW'(RD_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    OUT
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] row;
  logic [CW-1:0] col;
  logic [WW-1:0] wait_cnt;

  logic data_ready;
  logic last_pix;

  assign data_ready = (wait_cnt == WAIT_END);
  assign last_pix   = (row == LAST_POS) && (col == LAST_POS);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT:  if (data_ready) state_nxt = OUT;
      OUT: begin
        if (m_pix_ready) state_nxt = last_pix ? IDLE : ISSUE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs that are pure functions of state; the address follows col,
  // which only moves in OUT, so it is held through WAIT.
  always_comb begin
    bram_en_b   = (state == ISSUE);
    busy        = (state != IDLE);
    bram_addr_b = BASE_ADDR + 12'(col);
  end

  // Position counters, wait counter and the registered pixel stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      row         <= '0;
      col         <= '0;
      wait_cnt    <= '0;
      m_pix_data  <= '0;
      m_pix_valid <= 1'b0;
      m_pix_sof   <= 1'b0;
      m_pix_last  <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            row <= '0;
            col <= '0;
          end
        end
        ISSUE: wait_cnt <= '0;
        WAIT: begin
          if (data_ready) begin
            m_pix_data  <= bram_rddata_b[8*int'(row) +: 8];
            m_pix_valid <= 1'b1;
            m_pix_sof   <= (row == '0) && (col == '0);
            m_pix_last  <= (col == LAST_POS);
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        OUT: begin
          if (m_pix_ready) begin
            m_pix_valid <= 1'b0;
            m_pix_sof   <= 1'b0;
            m_pix_last  <= 1'b0;
            if (last_pix) begin
              frame_done <= 1'b1;
            end else if (col == LAST_POS) begin
              col <= '0;
              row <= row + CW'(1);
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fmap_readout_256.sv
// Directed bench for fmap_readout_256: three instances (RD_LAT 2/1/3, one at
// BASE_ADDR 12'hFF0) each behind a small BRAM model, exercised through one mux.
module tb_fmap_readout_256;

  localparam int NPIX   = 576;
  localparam int BUDGET = 20000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic ready = 1'b0;
  int   sel = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  logic [11:0]  addr_a  [3];
  logic         en_a    [3];
  logic [191:0] rd_a    [3];
  logic [7:0]   data_a  [3];
  logic         valid_a [3];
  logic         sof_a   [3];
  logic         last_a  [3];
  logic         busy_a  [3];
  logic         done_a  [3];
  logic         start_a [3];
  logic         ready_a [3];
  logic [191:0] p0, q0, q1;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      start_a[i] = (sel == i) && start;
      ready_a[i] = (sel == i) && ready;
    end
  end

  fmap_readout_256 #(.PIX_H(24), .BASE_ADDR(12'h000), .RD_LAT(2)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_a[0]),
    .bram_addr_b(addr_a[0]), .bram_en_b(en_a[0]), .bram_rddata_b(rd_a[0]),
    .m_pix_data(data_a[0]), .m_pix_valid(valid_a[0]), .m_pix_ready(ready_a[0]),
    .m_pix_sof(sof_a[0]), .m_pix_last(last_a[0]), .busy(busy_a[0]), .frame_done(done_a[0])
  );

  fmap_readout_256 #(.PIX_H(24), .BASE_ADDR(12'h000), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_a[1]),
    .bram_addr_b(addr_a[1]), .bram_en_b(en_a[1]), .bram_rddata_b(rd_a[1]),
    .m_pix_data(data_a[1]), .m_pix_valid(valid_a[1]), .m_pix_ready(ready_a[1]),
    .m_pix_sof(sof_a[1]), .m_pix_last(last_a[1]), .busy(busy_a[1]), .frame_done(done_a[1])
  );

  fmap_readout_256 #(.PIX_H(24), .BASE_ADDR(12'hFF0), .RD_LAT(3)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_a[2]),
    .bram_addr_b(addr_a[2]), .bram_en_b(en_a[2]), .bram_rddata_b(rd_a[2]),
    .m_pix_data(data_a[2]), .m_pix_valid(valid_a[2]), .m_pix_ready(ready_a[2]),
    .m_pix_sof(sof_a[2]), .m_pix_last(last_a[2]), .busy(busy_a[2]), .frame_done(done_a[2])
  );

  // Word for column c holds (c*24 + j) mod 256 in byte j.
  function automatic logic [191:0] word_at(input logic [11:0] a, input logic [11:0] base);
    logic [11:0]  c;
    logic [191:0] w;
    c = a - base;
    for (int j = 0; j < 24; j++) w[8*j +: 8] = 8'((int'(c) * 24 + j) % 256);
    return w;
  endfunction

  // BRAM models: data valid RD_LAT cycles after the enable cycle.
  always @(posedge clk) begin
    if (en_a[0]) p0 <= word_at(addr_a[0], 12'h000);
    rd_a[0] <= p0;
    if (en_a[1]) rd_a[1] <= word_at(addr_a[1], 12'h000);
    if (en_a[2]) q0 <= word_at(addr_a[2], 12'hFF0);
    q1      <= q0;
    rd_a[2] <= q1;
  end

  logic [11:0] obs_addr;
  logic        obs_en, obs_valid, obs_sof, obs_last, obs_busy, obs_done;
  logic [7:0]  obs_data;
  assign obs_addr  = addr_a[sel];
  assign obs_en    = en_a[sel];
  assign obs_valid = valid_a[sel];
  assign obs_sof   = sof_a[sel];
  assign obs_last  = last_a[sel];
  assign obs_busy  = busy_a[sel];
  assign obs_done  = done_a[sel];
  assign obs_data  = data_a[sel];

  function automatic int cur_lat();
    return (sel == 0) ? 2 : (sel == 1) ? 1 : 3;
  endfunction

  function automatic logic [11:0] cur_base();
    return (sel == 2) ? 12'hFF0 : 12'h000;
  endfunction

  function automatic logic [7:0] exp_pix(input int k);
    return 8'(((k % 24) * 24 + k / 24) % 256);
  endfunction

  // Drives one frame on the selected instance and checks it pixel by pixel.
  // pct: ready probability (100 = held high); poke_k: stray start at that
  // handshake; rst_k: reset while that pixel is valid; chain: raise start in
  // the frame_done cycle; pre_started: start already raised by the caller.
  task automatic run_frame(input int pct, input int poke_k, input int rst_k,
                           input bit pre_started, input bit chain);
    int k = 0, en_cnt = 0, done_cnt = 0, cyc = 0, last_hs = 0, first_v = -1;
    bit aborted = 1'b0;
    logic [11:0] exp_addr;
    if (!pre_started) begin
      @(negedge clk);
      start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    while (k < NPIX && !aborted && cyc < BUDGET) begin
      cyc++;
      if (start) start = 1'b0;
      if (obs_done) done_cnt++;
      if (obs_en) begin
        exp_addr = cur_base() + 12'(en_cnt % 24);
        total++;
        if (obs_addr !== exp_addr) begin
          bad++;
          $display("FAIL addr read=%0d got=%h want=%h", en_cnt, obs_addr, exp_addr);
        end
        en_cnt++;
      end
      ready = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
      if (obs_valid) begin
        if (first_v < 0) begin
          first_v = cyc;
          total++;
          if (first_v !== cur_lat() + 2) begin
            bad++;
            $display("FAIL first_valid got=%0d want=%0d", first_v, cur_lat() + 2);
          end
        end
        total++;
        if (obs_data !== exp_pix(k) || obs_sof !== (k == 0) || obs_last !== (k % 24 == 23)) begin
          bad++;
          $display("FAIL pixel k=%0d got data=%h sof=%b last=%b want data=%h sof=%b last=%b",
                   k, obs_data, obs_sof, obs_last, exp_pix(k), (k == 0), (k % 24 == 23));
        end
        if (k == rst_k) begin
          rst = 1'b1;
          aborted = 1'b1;
        end else if (ready) begin
          if (pct >= 100 && k > 0) begin
            total++;
            if (cyc - last_hs !== cur_lat() + 2) begin
              bad++;
              $display("FAIL spacing k=%0d got=%0d want=%0d", k, cyc - last_hs, cur_lat() + 2);
            end
          end
          last_hs = cyc;
          if (k == poke_k) start = 1'b1;
          k++;
        end
      end
      if (k < NPIX && !aborted) @(negedge clk);
    end
    if (aborted) begin
      @(negedge clk);
      total++;
      if (obs_valid !== 1'b0 || obs_sof !== 1'b0 || obs_last !== 1'b0 || obs_data !== 8'h00 ||
          obs_en !== 1'b0 || obs_busy !== 1'b0 || obs_done !== 1'b0 || obs_addr !== cur_base()) begin
        bad++;
        $display("FAIL reset_mid got v=%b s=%b l=%b d=%h en=%b busy=%b done=%b addr=%h want all zero addr=%h",
                 obs_valid, obs_sof, obs_last, obs_data, obs_en, obs_busy, obs_done, obs_addr, cur_base());
      end
      total++;
      if (done_cnt !== 0) begin
        bad++;
        $display("FAIL partial_done got=%0d want=0", done_cnt);
      end
      rst = 1'b0;
    end else if (k < NPIX) begin
      total++;
      bad++;
      $display("FAIL timeout pixels got=%0d want=%0d", k, NPIX);
    end else begin
      @(negedge clk);
      total++;
      if (obs_done !== 1'b1 || obs_busy !== 1'b0) begin
        bad++;
        $display("FAIL frame_done got done=%b busy=%b want done=1 busy=0", obs_done, obs_busy);
      end
      total++;
      if (en_cnt !== NPIX || done_cnt !== 0) begin
        bad++;
        $display("FAIL read_count got reads=%0d early_done=%0d want reads=%0d early_done=0",
                 en_cnt, done_cnt, NPIX);
      end
      if (chain) begin
        start = 1'b1;
      end else begin
        @(negedge clk);
        total++;
        if (obs_done !== 1'b0) begin
          bad++;
          $display("FAIL done_pulse got=%b want=0", obs_done);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      total++;
      if (obs_valid !== 1'b0 || obs_sof !== 1'b0 || obs_last !== 1'b0 || obs_data !== 8'h00 ||
          obs_en !== 1'b0 || obs_busy !== 1'b0 || obs_done !== 1'b0 || obs_addr !== cur_base()) begin
        bad++;
        $display("FAIL reset inst=%0d got v=%b d=%h en=%b busy=%b done=%b addr=%h want zeros addr=%h",
                 i, obs_valid, obs_data, obs_en, obs_busy, obs_done, obs_addr, cur_base());
      end
    end
    sel = 0;
    rst = 1'b0;
  endtask

  task automatic test_basic_frame();
    sel = 0;
    run_frame(100, -1, -1, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    sel = 0;
    run_frame(30, -1, -1, 1'b0, 1'b0);
  endtask

  task automatic test_ignored_start();
    sel = 0;
    run_frame(100, 100, -1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    sel = 0;
    run_frame(100, -1, 300, 1'b0, 1'b0);
    run_frame(100, -1, -1, 1'b0, 1'b0);
  endtask

  task automatic test_latency_sweep();
    sel = 1;
    run_frame(100, -1, -1, 1'b0, 1'b0);
    sel = 2;
    run_frame(100, -1, -1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    sel = 2;
    run_frame(100, -1, -1, 1'b0, 1'b1);
    run_frame(100, -1, -1, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_ignored_start();
    test_reset_mid_frame();
    test_latency_sweep();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
